cargo_sort_ctrl: RTL and testbench

CARGO_SORT_CTRL -- requirements
Module: cargo_sort_ctrl

---
 rtl/cargo_pkg.sv | 27 ++
 rtl/cargo_classifier.sv | 24 ++
 rtl/cargo_sort_ctrl.sv | 117 +++++++++++
 tb/tb_cargo_sort_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cargo_pkg.sv
// Shared encodings for the cargo sorter: item classes, FSM states and the
// class-to-diverter mapping.
package cargo_pkg;

    typedef enum logic [1:0] {
        CLS_REJECT = 2'd0,
        CLS_LIGHT  = 2'd1,
        CLS_MEDIUM = 2'd2,
        CLS_HEAVY  = 2'd3
    } cls_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLASSIFY = 2'd1;
    localparam logic [1:0] ST_WAIT_BIN = 2'd2;
    localparam logic [1:0] ST_GATE     = 2'd3;

    // Diverter bit order is {heavy, medium, light}; rejects open no gate.
    function automatic logic [2:0] cls_onehot(input cls_t c);
        case (c)
            CLS_LIGHT:  return 3'b001;
            CLS_MEDIUM: return 3'b010;
            CLS_HEAVY:  return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/cargo_classifier.sv
// Combinational weight classifier: zero rejects, then inclusive light and
// medium upper bounds, everything else heavy.
module cargo_classifier
    import cargo_pkg::*;
#(
    parameter int unsigned W_WIDTH = 4
) (
    input  logic [W_WIDTH-1:0] weight,
    input  logic [W_WIDTH-1:0] thr_light,
    input  logic [W_WIDTH-1:0] thr_medium,
    output cls_t               cls
);

    always_comb begin
        cls = CLS_HEAVY;
        if (weight == '0)
            cls = CLS_REJECT;
        else if (weight <= thr_light)
            cls = CLS_LIGHT;
        else if (weight <= thr_medium)
            cls = CLS_MEDIUM;
    end

endmodule

// File: rtl/cargo_sort_ctrl.sv
// Cargo sorter controller: accepts one weighed item at a time, classifies it,
// waits for bin space if needed and holds the matching diverter gate open.
module cargo_sort_ctrl
    import cargo_pkg::*;
#(
    parameter int unsigned W_WIDTH     = 4,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned BIN_CAP     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_WIDTH-1:0]   weight,
    input  logic [W_WIDTH-1:0]   thr_light,
    input  logic [W_WIDTH-1:0]   thr_medium,
    input  logic                 clr_counts,
    output logic [2:0]           gate,
    output logic                 reject,
    output logic [2:0]           bin_full,
    output logic [CNT_WIDTH-1:0] cnt_light,
    output logic [CNT_WIDTH-1:0] cnt_medium,
    output logic [CNT_WIDTH-1:0] cnt_heavy
);

    localparam logic [CNT_WIDTH-1:0] CAP       = CNT_WIDTH'(BIN_CAP);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [7:0]           GATE_LAST = 8'(GATE_CYCLES - 1);

    logic [1:0]           state;
    cls_t                 cls_next;
    cls_t                 cls_q;
    logic [7:0]           gate_cnt;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [2:0]           tgt;
    logic                 target_full;
    logic                 enter_gate;

    cargo_classifier #(
        .W_WIDTH(W_WIDTH)
    ) u_classifier (
        .weight     (weight),
        .thr_light  (thr_light),
        .thr_medium (thr_medium),
        .cls        (cls_next)
    );

    assign tgt         = cls_onehot(cls_q);
    assign bin_full    = {cnt_q[2] == CAP, cnt_q[1] == CAP, cnt_q[0] == CAP};
    assign target_full = |(tgt & bin_full);
    assign in_ready    = (state == ST_IDLE) && !rst;
    assign gate        = (state == ST_GATE) ? tgt : 3'b000;
    assign cnt_light   = cnt_q[0];
    assign cnt_medium  = cnt_q[1];
    assign cnt_heavy   = cnt_q[2];

    // The bin count is taken on the same edge the FSM enters GATE.
    assign enter_gate = ((state == ST_CLASSIFY) && (cls_q != CLS_REJECT) && !target_full)
                     || ((state == ST_WAIT_BIN) && clr_counts);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cls_q    <= CLS_REJECT;
            gate_cnt <= '0;
            reject   <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_CLASSIFY;
                        cls_q <= cls_next;
                    end
                end
                ST_CLASSIFY: begin
                    if (cls_q == CLS_REJECT) begin
                        reject <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (target_full) begin
                        state <= ST_WAIT_BIN;
                    end else begin
                        state    <= ST_GATE;
                        gate_cnt <= GATE_LAST;
                    end
                end
                ST_WAIT_BIN: begin
                    if (clr_counts) begin
                        state    <= ST_GATE;
                        gate_cnt <= GATE_LAST;
                    end
                end
                ST_GATE: begin
                    if (gate_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gate_cnt <= gate_cnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A clear coinciding with an increment leaves the target bin at one.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (rst)
                cnt_q[i] <= '0;
            else if (clr_counts)
                cnt_q[i] <= (enter_gate && tgt[i]) ? CNT_ONE : '0;
            else if (enter_gate && tgt[i])
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cargo_sort_ctrl.sv
// Self-checking bench for cargo_sort_ctrl: directed scenarios plus random
// traffic, all compared every cycle against a timestamp-based item model.
module tb_cargo_sort_ctrl;

    localparam int unsigned W   = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned G   = 4;
    localparam int unsigned CAP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  weight = '0;
    logic [W-1:0]  thr_light = '0;
    logic [W-1:0]  thr_medium = '0;
    logic          clr_counts = 1'b0;
    logic [2:0]    gate;
    logic          reject;
    logic [2:0]    bin_full;
    logic [CW-1:0] cnt_light;
    logic [CW-1:0] cnt_medium;
    logic [CW-1:0] cnt_heavy;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int tl_cur   = 3;
    int tm_cur   = 6;

    // Item model: one item in flight, described by the edges at which things happen.
    bit m_busy = 0, m_gating = 0, m_waiting = 0, m_xfer = 0;
    int m_cls = 0, m_decide = 0, m_gate_from = 0, m_rej_edge = -10;
    int m_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    cargo_sort_ctrl #(
        .W_WIDTH     (W),
        .CNT_WIDTH   (CW),
        .GATE_CYCLES (G),
        .BIN_CAP     (CAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .weight     (weight),
        .thr_light  (thr_light),
        .thr_medium (thr_medium),
        .clr_counts (clr_counts),
        .gate       (gate),
        .reject     (reject),
        .bin_full   (bin_full),
        .cnt_light  (cnt_light),
        .cnt_medium (cnt_medium),
        .cnt_heavy  (cnt_heavy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int classify(input int w, input int tl, input int tm);
        if (w == 0)  return 0;
        if (w <= tl) return 1;
        if (w <= tm) return 2;
        return 3;
    endfunction

    task automatic model_edge();
        bit start;
        bit xfer;
        start  = 0;
        xfer   = 0;
        m_xfer = 0;
        if (rst) begin
            m_busy = 0; m_gating = 0; m_waiting = 0; m_rej_edge = -10;
            m_cnt = '{0, 0, 0};
        end else begin
            xfer = in_valid && !m_busy;
            if (m_busy && !m_gating && !m_waiting && edge_n == m_decide) begin
                if (m_cls == 0) begin
                    m_rej_edge = edge_n;
                    m_busy = 0;
                end else if (m_cnt[m_cls-1] == int'(CAP)) begin
                    m_waiting = 1;
                end else begin
                    start = 1;
                end
            end else if (m_waiting && clr_counts) begin
                m_waiting = 0;
                start = 1;
            end else if (m_gating && edge_n == m_gate_from + int'(G)) begin
                m_gating = 0;
                m_busy = 0;
            end
            if (clr_counts) m_cnt = '{0, 0, 0};
            if (start) begin
                m_gating = 1;
                m_gate_from = edge_n;
                m_cnt[m_cls-1] = m_cnt[m_cls-1] + 1;
            end
            if (xfer) begin
                m_busy = 1;
                m_xfer = 1;
                m_cls = classify(int'(weight), int'(thr_light), int'(thr_medium));
                m_decide = edge_n + 1;
            end
        end
    endtask

    task automatic check_all();
        logic [2:0] exp_gate;
        logic [2:0] exp_full;
        exp_gate = m_gating ? 3'(1 << (m_cls - 1)) : 3'b000;
        exp_full = {m_cnt[2] == int'(CAP), m_cnt[1] == int'(CAP), m_cnt[0] == int'(CAP)};
        check_eq("gate", 32'(gate), 32'(exp_gate));
        check_eq("reject", 32'(reject), 32'(m_rej_edge == edge_n));
        check_eq("in_ready", 32'(in_ready), 32'(!rst && !m_busy));
        check_eq("cnt_light", 32'(cnt_light), m_cnt[0]);
        check_eq("cnt_medium", 32'(cnt_medium), m_cnt[1]);
        check_eq("cnt_heavy", 32'(cnt_heavy), m_cnt[2]);
        check_eq("bin_full", 32'(bin_full), 32'(exp_full));
    endtask

    task automatic cycle(input bit r, input bit v, input int w, input int tl, input int tm, input bit c);
        rst        = r;
        in_valid   = v;
        weight     = W'(w);
        thr_light  = W'(tl);
        thr_medium = W'(tm);
        clr_counts = c;
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Keeps in_valid high, with junk weights while busy, until the item is taken.
    task automatic send_item(input int w);
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1, m_busy ? int'($urandom_range(0, 15)) : w, tl_cur, tm_cur, 0);
            if (m_xfer) break;
        end
        check_eq("accept", 32'(m_xfer), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!m_busy) break;
            cycle(0, 0, int'($urandom_range(0, 15)), tl_cur, tm_cur, 0);
        end
        check_eq("idle_wait", 32'(m_busy), 32'd0);
    endtask

    task automatic pulse_clear();
        cycle(0, 0, 0, tl_cur, tm_cur, 1);
    endtask

    initial begin
        int seq [6];
        seq = '{1, 3, 4, 6, 7, 15};

        cycle(1, 0, 0, 3, 6, 0);
        cycle(1, 1, 5, 3, 6, 0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_gate", 32'(gate), 32'd0);
        check_eq("rst_cnt_light", 32'(cnt_light), 32'd0);
        cycle(0, 0, 0, 3, 6, 0);

        // Back-to-back items across all three classes.
        foreach (seq[k]) send_item(seq[k]);
        wait_idle();
        check_eq("b2b_light", 32'(cnt_light), 32'd2);
        check_eq("b2b_medium", 32'(cnt_medium), 32'd2);
        check_eq("b2b_heavy", 32'(cnt_heavy), 32'd2);

        // Zero weight: single-cycle reject, no count.
        pulse_clear();
        send_item(0);
        cycle(0, 0, 0, tl_cur, tm_cur, 0);
        check_eq("rej_pulse", 32'(reject), 32'd1);
        check_eq("rej_ready", 32'(in_ready), 32'd1);
        cycle(0, 0, 0, tl_cur, tm_cur, 0);
        check_eq("rej_done", 32'(reject), 32'd0);
        check_eq("rej_cnt_light", 32'(cnt_light), 32'd0);

        // Full bin stalls until cleared.
        send_item(2);
        send_item(2);
        send_item(2);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, tl_cur, tm_cur, 0);
        check_eq("wait_gate", 32'(gate), 32'd0);
        check_eq("wait_ready", 32'(in_ready), 32'd0);
        pulse_clear();
        check_eq("wait_release_gate", 32'(gate), 32'b001);
        check_eq("wait_release_cnt", 32'(cnt_light), 32'd1);
        wait_idle();

        // Inverted thresholds leave medium unused.
        tl_cur = 8; tm_cur = 5;
        pulse_clear();
        send_item(7);
        send_item(9);
        wait_idle();
        check_eq("inv_light", 32'(cnt_light), 32'd1);
        check_eq("inv_medium", 32'(cnt_medium), 32'd0);
        check_eq("inv_heavy", 32'(cnt_heavy), 32'd1);

        // Reset during the second gate cycle aborts the item.
        tl_cur = 3; tm_cur = 6;
        pulse_clear();
        send_item(1);
        cycle(0, 0, 0, tl_cur, tm_cur, 0);
        cycle(0, 0, 0, tl_cur, tm_cur, 0);
        check_eq("pre_rst_gate", 32'(gate), 32'b001);
        cycle(1, 0, 0, tl_cur, tm_cur, 0);
        check_eq("abort_gate", 32'(gate), 32'd0);
        check_eq("abort_cnt", 32'(cnt_light), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 32'(in_ready), 32'd1);

        // Random traffic including clears, resets and changing thresholds.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
